// File: rtl/lane_merge4.sv
// Four-lane round-robin merge into one registered output stage with
// valid/ready handshakes on every lane and a delivered-word counter.
module lane_merge4 #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      in_valid,
    input  logic [size-1:0] in_data1,
    input  logic [size-1:0] in_data2,
    input  logic [size-1:0] in_data3,
    input  logic [size-1:0] in_data4,
    output logic [3:0]      in_ready,
    output logic            out_valid,
    output logic [size-1:0] out_data,
    output logic [1:0]      out_sel,
    input  logic            out_ready,
    output logic [15:0]     out_count
);

    logic            out_valid_q, out_valid_d;
    logic [size-1:0] out_data_q, out_data_d;
    logic [1:0]      out_sel_q, out_sel_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]     out_count_q, out_count_d;

    logic [size-1:0] lane_data [4];
    logic [3:0]      rot_valid;
    logic            load_en;
    logic            grant_found;
    logic [1:0]      grant_idx;
    logic            in_xfer;

    assign lane_data[0] = in_data1;
    assign lane_data[1] = in_data2;
    assign lane_data[2] = in_data3;
    assign lane_data[3] = in_data4;

    // Rotate the request vector so that position 0 is the current priority lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_valid[gi] = in_valid[rr_ptr_q + 2'(gi)];
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = rr_ptr_q + 2'(k);
            end
        end
    end

    assign load_en = !out_valid_q || out_ready;
    assign in_xfer = grant_found && load_en && !reset;

    always_comb begin
        in_ready = 4'b0000;
        if (in_xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        out_count_d = out_count_q;
        if (out_valid_q && out_ready) begin
            out_count_d = out_count_q + 16'd1;
        end
        if (load_en) begin
            out_valid_d = grant_found;
            if (grant_found) begin
                out_data_d = lane_data[grant_idx];
                out_sel_d  = grant_idx;
                rr_ptr_d   = grant_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            rr_ptr_q    <= 2'd0;
            out_count_q <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_lane_merge4.sv
// Directed vector bench for lane_merge4: a table of per-cycle stimulus with
// hand-computed results, plus a counter wrap sequence.
module tb_lane_merge4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [7:0]  in_data1, in_data2, in_data3, in_data4;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic [15:0] out_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lane_merge4 #(.size(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_data4  (in_data4),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic [7:0]  d1, d2, d3, d4;
        logic        ordy;
        logic [3:0]  exp_ir;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_os;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] iv,
                                input logic [7:0] d1, input logic [7:0] d2,
                                input logic [7:0] d3, input logic [7:0] d4,
                                input logic ordy, input logic [3:0] ir,
                                input logic ov, input logic [7:0] od,
                                input logic [1:0] os, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.d4 = d4;
        v.ordy = ordy; v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od;
        v.exp_os = os; v.exp_cnt = cnt;
        return v;
    endfunction

    initial begin
        //                rst iv       d1     d2     d3     d4     ordy ir       ov od     os     cnt
        vecs[0]  = mk(1'b0, 4'b0010, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b1, 4'b0010, 1'b1, 8'hA5, 2'd1, 16'd0);
        vecs[1]  = mk(1'b0, 4'b0000, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd1, 16'd1);
        // priority pointer at lane 3, only lanes 1/2 requesting: lane 1 wins
        vecs[2]  = mk(1'b0, 4'b0011, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd1);
        // reset while a word is held and all lanes request
        vecs[3]  = mk(1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 16'd0);
        vecs[4]  = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd0);
        vecs[5]  = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1, 16'd1);
        vecs[6]  = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2, 16'd2);
        vecs[7]  = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3, 16'd3);
        vecs[8]  = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd4);
        // downstream stalls three cycles
        vecs[9]  = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 16'd4);
        vecs[10] = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 16'd4);
        vecs[11] = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 16'd4);
        vecs[12] = mk(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1, 16'd5);
        // no requests: data must not be captured from idle lanes
        vecs[13] = mk(1'b0, 4'b0000, 8'h55, 8'h55, 8'h55, 8'h55, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1, 16'd6);
        vecs[14] = mk(1'b0, 4'b0000, 8'h55, 8'h55, 8'h55, 8'h55, 1'b0, 4'b0000, 1'b0, 8'h22, 2'd1, 16'd6);
        vecs[15] = mk(1'b0, 4'b0001, 8'h66, 8'h55, 8'h55, 8'h55, 1'b0, 4'b0001, 1'b1, 8'h66, 2'd0, 16'd6);
        vecs[16] = mk(1'b0, 4'b1000, 8'h66, 8'h55, 8'h55, 8'h77, 1'b0, 4'b0000, 1'b1, 8'h66, 2'd0, 16'd6);
        vecs[17] = mk(1'b0, 4'b1000, 8'h66, 8'h55, 8'h55, 8'h77, 1'b1, 4'b1000, 1'b1, 8'h77, 2'd3, 16'd7);

        reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data1 = 8'h11; in_data2 = 8'h22; in_data3 = 8'h33; in_data4 = 8'h44;
        @(posedge clk); #1;
        chk("reset_in_ready", -1, 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        chk("reset_out_valid", -1, 32'(out_valid), 32'h0);
        chk("reset_out_data",  -1, 32'(out_data),  32'h0);
        chk("reset_out_sel",   -1, 32'(out_sel),   32'h0);
        chk("reset_out_count", -1, 32'(out_count), 32'h0);
        reset = 1'b0; in_valid = 4'b0000;

        for (int i = 0; i < 18; i++) begin
            reset = vecs[i].rst; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
            in_data1 = vecs[i].d1; in_data2 = vecs[i].d2;
            in_data3 = vecs[i].d3; in_data4 = vecs[i].d4;
            #4;
            chk("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_ir));
            @(posedge clk); #1;
            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_ov));
            chk("out_data",  i, 32'(out_data),  32'(vecs[i].exp_od));
            chk("out_sel",   i, 32'(out_sel),   32'(vecs[i].exp_os));
            chk("out_count", i, 32'(out_count), 32'(vecs[i].exp_cnt));
            $display("vec %0d: rst=%b iv=%b ordy=%b -> in_ready=%b out_valid=%b out_data=%h out_sel=%0d out_count=%0d",
                     i, vecs[i].rst, vecs[i].iv, vecs[i].ordy, in_ready, out_valid, out_data, out_sel, out_count);
        end

        // Counter wrap: continuous traffic, one word per cycle.
        reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        begin
            int bubbles;
            bubbles = 0;
            for (int n = 0; n < 65536; n++) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1) bubbles++;
            end
            chk("throughput_bubbles", -1, 32'(bubbles), 32'h0);
        end
        chk("count_ffff", -1, 32'(out_count), 32'h0000FFFF);
        $display("wrap: out_count=%h before final transfer", out_count);
        @(posedge clk); #1;
        chk("count_wrap", -1, 32'(out_count), 32'h0);
        $display("wrap: out_count=%h after final transfer", out_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_merge4.md
LANE_MERGE4 -- requirements
Module: lane_merge4

Interface
REQ-001 The block SHALL have parameter size, default 8, giving the data width of every lane in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 4 bits: bit i high means lane i+1 is offering a word.
REQ-005 The block SHALL have ports in_data1..in_data4, input, size bits each: lane 1..4 data.
REQ-006 The block SHALL have port in_ready, output, 4 bits: bit i high means lane i+1's word is accepted this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data and out_sel hold a valid word.
REQ-008 The block SHALL have port out_data, output, size bits: the merged word.
REQ-009 The block SHALL have port out_sel, output, 2 bits: source lane tag (00=lane1, 01=lane2, 10=lane3, 11=lane4), the same encoding as the 1:4 demux sel.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word this cycle.
REQ-011 The block SHALL have port out_count, output, 16 bits: number of words delivered downstream.

Function
REQ-012 A transfer SHALL occur on any port in a cycle where its valid and ready are both high at the clk edge.
REQ-013 load_en SHALL be defined as (!out_valid || out_ready); the output register SHALL load only when load_en is high.
REQ-014 Arbitration SHALL be round-robin using a 2-bit priority pointer rr_ptr: lanes are searched in order rr_ptr, rr_ptr+1, ... (mod 4), and the first lane with in_valid high is granted.
REQ-015 in_ready SHALL be combinational: in_ready[g] = load_en for granted lane g only; all other bits SHALL be 0, so at most one bit is high per cycle.
REQ-016 No in_ready bit SHALL be high when load_en is low or no in_valid bit is high.
REQ-017 On an input transfer from lane g, the next cycle SHALL give out_valid=1, out_data=that lane's data, out_sel=g, and rr_ptr SHALL become (g+1) mod 4.
REQ-018 When load_en is high and no lane transfers, out_valid SHALL go to 0 the next cycle; out_data, out_sel and rr_ptr SHALL hold their values.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_sel SHALL hold stable and in_ready SHALL be 0000.
REQ-020 Latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-021 With out_ready held high and lanes continuously valid, throughput SHALL be 1 word per cycle.
REQ-022 A simultaneous output transfer and new input transfer in the same cycle SHALL replace the word without a bubble.
REQ-023 out_count SHALL increment by 1 on each output transfer and SHALL wrap from 16'hFFFF to 0.
REQ-024 Upstream lanes SHALL hold in_data stable while in_valid is high and in_ready is low; the block SHALL NOT latch a lane's data in cycles where that lane does not transfer.

Reset
REQ-025 While reset is high at a clk edge, the block SHALL set out_valid=0, out_data=0, out_sel=00, rr_ptr=00 and out_count=0.
REQ-026 During any cycle with reset high, in_ready SHALL be 0000.
REQ-027 A reset asserted mid-stream SHALL discard the held output word, and no input transfer SHALL be recorded in that cycle.
REQ-028 After reset deasserts, lane 1 SHALL hold highest priority.

Verification
REQ-029 Scenario: after reset, in_valid=0010, in_data2=8'hA5, out_ready=1 -> in_ready=0010; next cycle out_valid=1, out_data=A5, out_sel=01; following cycle out_valid=0 and out_count=1.
REQ-030 Scenario: all four lanes held valid with data 11/22/33/44, out_ready=1 -> outputs 11,22,33,44,11 on consecutive cycles with out_sel 00,01,10,11,00.
REQ-031 Scenario: word held with out_ready=0 for 3 cycles while in_valid=1111 -> out_data stable, in_ready=0000 throughout, out_count unchanged; on out_ready=1 the next lane transfers in the same cycle.
REQ-032 Scenario: rr_ptr=10 and in_valid=0011 -> lane 1 is granted (search order 3,4,1,2); then rr_ptr=01.
REQ-033 Scenario: reset pulsed while out_valid=1 and in_valid=1111 -> next cycle out_valid=0, out_count=0, in_ready=0000 during reset; the first grant after reset goes to lane 1.
REQ-034 Scenario: preload out_count=16'hFFFF by 65535 transfers, then 1 more transfer -> out_count=0.
